// File: rtl/fp_dec_pkg.sv
// Shared constants and state encoding for the IEEE-754 binary32 to fixed-point decoder.
// Also carries the field-slice positions and saturation words.
package fp_dec_pkg;

  localparam int PRECISION  = 32;
  localparam int EXPONENT   = 8;
  localparam int FRACTION   = 23;
  localparam int BIAS       = 127;
  localparam int INT_W      = 16;
  localparam int FRAC_W     = 32;
  localparam int SHIFT_STEP = 8;

  localparam int OUT_W    = INT_W + FRAC_W;
  localparam int SIGN_BIT = PRECISION - 1;
  localparam int EXP_MSB  = PRECISION - 2;
  localparam int EXP_LSB  = FRACTION;
  localparam int FRAC_MSB = FRACTION - 1;

  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLASSIFY = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_FINISH   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/fp_to_fixed_decoder_unpack.sv
// Combinational IEEE-754 field splitter: sign, fraction, unbiased exponent and
// zero/inf/nan classification (subnormals report as zero).
module fp_unpack #(
  parameter int PRECISION = 32,
  parameter int EXPONENT  = 8,
  parameter int FRACTION  = 23,
  parameter int BIAS      = 127
) (
  input  logic [PRECISION-1:0]      i_word,
  output logic                      o_sign,
  output logic [FRACTION-1:0]       o_frac,
  output logic signed [EXPONENT:0]  o_exp_unb,
  output logic                      o_is_zero,
  output logic                      o_is_inf,
  output logic                      o_is_nan
);

  localparam logic [EXPONENT:0] BIAS_V = (EXPONENT+1)'(BIAS);

  logic [EXPONENT-1:0] w_exp;
  logic                w_exp_max;
  logic                w_exp_min;
  logic                w_frac_nz;

  assign o_sign    = i_word[PRECISION-1];
  assign w_exp     = i_word[PRECISION-2 -: EXPONENT];
  assign o_frac    = i_word[FRACTION-1:0];
  assign o_exp_unb = $signed({1'b0, w_exp}) - $signed(BIAS_V);

  assign w_exp_max = &w_exp;
  assign w_exp_min = ~|w_exp;
  assign w_frac_nz = |o_frac;

  assign o_is_zero = w_exp_min;
  assign o_is_inf  = w_exp_max & ~w_frac_nz;
  assign o_is_nan  = w_exp_max & w_frac_nz;

endmodule

// File: rtl/fp_to_fixed_decoder.sv
// Iterative binary32 -> signed Q(INT_W).(FRAC_W) converter with saturation flags and
// a key-byte tap; one word in flight, valid/ready on both sides.
module fp_to_fixed_decoder #(
  parameter int PRECISION  = fp_dec_pkg::PRECISION,
  parameter int EXPONENT   = fp_dec_pkg::EXPONENT,
  parameter int FRACTION   = fp_dec_pkg::FRACTION,
  parameter int BIAS       = fp_dec_pkg::BIAS,
  parameter int INT_W      = fp_dec_pkg::INT_W,
  parameter int FRAC_W     = fp_dec_pkg::FRAC_W,
  parameter int SHIFT_STEP = fp_dec_pkg::SHIFT_STEP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PRECISION-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [INT_W+FRAC_W-1:0] out_fixed,
  output logic [7:0]              out_byte,
  output logic                    out_ovf,
  output logic                    out_unf,
  output logic                    out_nan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  import fp_dec_pkg::*;

  localparam int OUT_W = INT_W + FRAC_W;
  localparam int ACC_W = OUT_W + FRACTION + 1;
  localparam int S_W   = EXPONENT + 3;

  localparam logic signed [S_W-1:0] S_OFF = S_W'(FRAC_W - FRACTION);
  localparam logic signed [S_W-1:0] E_OVF = S_W'(INT_W - 1);
  localparam logic signed [S_W-1:0] E_UNF = S_W'(-FRAC_W);
  localparam logic [S_W-1:0]        STEP  = S_W'(SHIFT_STEP);

  localparam logic [OUT_W-1:0] SAT_POS_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG_V = {1'b1, {(OUT_W-1){1'b0}}};

  state_t              r_state;
  logic [PRECISION-1:0] r_word;
  logic [ACC_W-1:0]    r_acc;
  logic [S_W-1:0]      r_rem;
  logic                r_left;
  logic [OUT_W-1:0]    r_out_fixed;
  logic [7:0]          r_out_byte;
  logic                r_out_ovf;
  logic                r_out_unf;
  logic                r_out_nan;
  logic                r_out_valid;

  logic                    w_sign;
  logic [FRACTION-1:0]     w_frac;
  logic signed [EXPONENT:0] w_exp_unb;
  logic                    w_is_zero;
  logic                    w_is_inf;
  logic                    w_is_nan;
  logic signed [S_W-1:0]   w_e_ext;
  logic signed [S_W-1:0]   w_s;
  logic [S_W-1:0]          w_s_abs;
  logic                    w_ovf_cls;
  logic                    w_special;
  logic [S_W-1:0]          w_amt;
  logic [S_W-1:0]          w_rem_next;
  logic [OUT_W-1:0]        w_mag;
  logic                    w_sat;

  fp_unpack #(
    .PRECISION (PRECISION),
    .EXPONENT  (EXPONENT),
    .FRACTION  (FRACTION),
    .BIAS      (BIAS)
  ) u_unpack (
    .i_word    (r_word),
    .o_sign    (w_sign),
    .o_frac    (w_frac),
    .o_exp_unb (w_exp_unb),
    .o_is_zero (w_is_zero),
    .o_is_inf  (w_is_inf),
    .o_is_nan  (w_is_nan)
  );

  assign w_e_ext   = {{(S_W-EXPONENT-1){w_exp_unb[EXPONENT]}}, w_exp_unb};
  assign w_s       = w_e_ext + S_OFF;
  assign w_s_abs   = w_s[S_W-1] ? -w_s : w_s;
  assign w_ovf_cls = w_is_inf | (~w_is_zero & ~w_is_nan & (w_e_ext >= E_OVF));
  assign w_special = w_is_zero | w_is_nan | w_ovf_cls | (w_e_ext < E_UNF);

  assign w_amt      = (r_rem < STEP) ? r_rem : STEP;
  assign w_rem_next = r_rem - w_amt;

  // Integer bit of the significand sits at acc[FRACTION]; after shifting, acc[OUT_W-1:0]
  // is the magnitude in fixed-point units. Any bit at or above the sign position saturates.
  assign w_mag = r_acc[OUT_W-1:0];
  assign w_sat = ~w_is_nan & (w_ovf_cls | (|r_acc[ACC_W-1:OUT_W-1]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_word      <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_left      <= 1'b0;
      r_out_fixed <= '0;
      r_out_byte  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_unf   <= 1'b0;
      r_out_nan   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_word  <= in_data;
            r_state <= ST_CLASSIFY;
          end
        end
        ST_CLASSIFY: begin
          if (w_special) begin
            r_acc   <= '0;
            r_state <= ST_FINISH;
          end else begin
            r_acc   <= ACC_W'({1'b1, w_frac});
            r_left  <= ~w_s[S_W-1];
            r_rem   <= w_s_abs;
            r_state <= (w_s_abs == '0) ? ST_FINISH : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc <= r_left ? (r_acc << w_amt) : (r_acc >> w_amt);
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_out_byte <= w_mag[FRAC_W-1 -: 8];
          if (w_is_nan) begin
            r_out_fixed <= '0;
          end else if (w_sat) begin
            r_out_fixed <= w_sign ? SAT_NEG_V : SAT_POS_V;
          end else begin
            r_out_fixed <= w_sign ? -w_mag : w_mag;
          end
          r_out_nan   <= w_is_nan;
          r_out_ovf   <= w_sat;
          r_out_unf   <= ~w_is_nan & ~w_sat & ~w_is_zero & (w_mag == '0);
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_fixed = r_out_fixed;
  assign out_byte  = r_out_byte;
  assign out_ovf   = r_out_ovf;
  assign out_unf   = r_out_unf;
  assign out_nan   = r_out_nan;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fp_to_fixed_decoder.sv
// Directed + randomized bench for fp_to_fixed_decoder; expected values come from a
// real-arithmetic model of the float value scaled by 2^32.
module tb_fp_to_fixed_decoder;
  import fp_dec_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] out_fixed;
  logic [7:0]  out_byte;
  logic        out_ovf;
  logic        out_unf;
  logic        out_nan;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  fp_to_fixed_decoder #(
    .PRECISION  (32),
    .EXPONENT   (8),
    .FRACTION   (23),
    .BIAS       (127),
    .INT_W      (16),
    .FRAC_W     (32),
    .SHIFT_STEP (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_fixed (out_fixed),
    .out_byte  (out_byte),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_nan   (out_nan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value = (1 + frac/2^23) * 2^(exp-127); fixed result = trunc(|value| * 2^32) with sign.
  // Latency (edges after capture until out_valid) = 2 + ceil(|s|/8), s = exp-127-23+32.
  function automatic void model(input logic [31:0] w, output logic [47:0] fx,
                                output logic [7:0] by, output logic ovf,
                                output logic unf, output logic nan, output int lat);
    int          ex;
    int          fr;
    int          s;
    real         a;
    real         x;
    longint      t;
    logic [63:0] tv;
    ex  = int'(w[30:23]);
    fr  = int'(w[22:0]);
    ovf = 1'b0; unf = 1'b0; nan = 1'b0; lat = 2; t = 0;
    if (ex == 255) begin
      if (fr != 0) nan = 1'b1;
      else ovf = 1'b1;
    end else if (ex != 0) begin
      a = (1.0 + real'(fr) / 8388608.0) * (2.0 ** (real'(ex) - 127.0));
      if (a >= 32768.0) begin
        ovf = 1'b1;
      end else begin
        x = a * 4294967296.0;
        t = longint'(x);
        if (real'(t) > x) t = t - 1;
        if (t == 0) begin
          unf = 1'b1;
        end else begin
          s = ex - 127 + 9;
          if (s < 0) s = -s;
          lat = 2 + (s + 7) / 8;
        end
      end
    end
    tv = t;
    by = tv[31:24];
    if (w[31]) tv = -tv;
    if (nan) fx = '0;
    else if (ovf) fx = w[31] ? SAT_NEG : SAT_POS;
    else fx = tv[47:0];
  endfunction

  task automatic run(input logic [31:0] w, input int hold);
    logic [47:0] efx;
    logic [7:0]  eby;
    logic        eo;
    logic        eu;
    logic        en;
    int          elat;
    int          lat;
    int          n;
    string       tag;
    tag = $sformatf("%h", w);
    model(w, efx, eby, eo, eu, en, elat);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    for (int c = 0; c <= hold; c++) begin
      check({tag, " fixed"}, 64'(out_fixed), 64'(efx));
      check({tag, " ovf"}, 64'(out_ovf), 64'(eo));
      check({tag, " unf"}, 64'(out_unf), 64'(eu));
      check({tag, " nan"}, 64'(out_nan), 64'(en));
      if (!eo) check({tag, " byte"}, 64'(out_byte), 64'(eby));
      check({tag, " in_ready_busy"}, 64'(in_ready), 64'd0);
      check({tag, " valid_held"}, 64'(out_valid), 64'd1);
      if (c < hold) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  logic [31:0] directed [$] = '{
    32'h3F800000, 32'h3F000000, 32'h47800000, 32'hFF800000, 32'h7FC00000,
    32'h2F800000, 32'h00000000, 32'h80000000, 32'h00400000, 32'h2F000000,
    32'h46FFFFFF, 32'h47000000, 32'hC7000000, 32'h7F800000, 32'hFFC00001,
    32'hC6FFFFFF, 32'hAF800000, 32'h3F800001
  };

  initial begin
    logic [31:0] w;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_fixed", 64'(out_fixed), 64'd0);
    check("reset out_byte", 64'(out_byte), 64'd0);
    check("reset flags", 64'({out_ovf, out_unf, out_nan}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Spec anchors against literal values
    run(32'h3F800000, 0);
    check("1.0 literal", 64'(out_fixed), 64'h0000_0001_0000_0000);
    run(32'hC0200000, 5);
    check("-2.5 literal", 64'(out_fixed), 64'h0000_FFFD_8000_0000);
    check("-2.5 byte literal", 64'(out_byte), 64'h80);

    foreach (directed[i]) run(directed[i], 0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom();
      end else begin
        w[31]    = 1'($urandom_range(0, 1));
        w[30:23] = 8'($urandom_range(90, 150));
        w[22:0]  = 23'($urandom());
      end
      run(w, $urandom_range(0, 3));
    end

    // Reset while the accumulator is shifting
    in_data  = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset in_ready", 64'(in_ready), 64'd1);
    check("midreset out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midreset no_output", 64'(out_valid), 64'd0);
    run(32'h3F000000, 0);
    check("post-reset 0.5 literal", 64'(out_fixed), 64'h0000_0000_8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
